// File: rtl/ram_bridge.sv
// Bridges zerocore fetch/data ports onto a single-read/single-write word RAM.
// Data has fixed priority; every granted access is answered exactly one cycle later.
module ram_bridge #(
  parameter int unsigned        ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_inst,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_wen,
  input  logic [1:0]        d_req_size,
  input  logic              d_req_signed,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [63:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [63:0]       d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_ridx,
  input  logic [63:0]       ram_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_widx,
  output logic [63:0]       ram_wdata,
  output logic [63:0]       ram_wmask
);

  typedef enum logic [1:0] {IDLE, PEND_IF, PEND_D} state_t;

  state_t            r_state;
  logic              r_wen;
  logic [2:0]        r_off;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_err;

  logic              w_d_gnt;
  logic              w_if_gnt;
  logic              w_d_mis;
  logic              w_d_err;
  logic              w_if_err;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_idx;
  logic [2:0]        w_off;
  logic [63:0]       w_lanes;
  logic [63:0]       w_shift;
  logic [63:0]       w_ext;

  // Grant, error check and RAM drive for the request granted this cycle
  always_comb begin
    w_d_gnt  = !rst && d_req_valid;
    w_if_gnt = !rst && if_req_valid && !d_req_valid;
    unique case (d_req_size)
      2'd0:    w_d_mis = 1'b0;
      2'd1:    w_d_mis = d_req_addr[0];
      2'd2:    w_d_mis = |d_req_addr[1:0];
      default: w_d_mis = |d_req_addr[2:0];
    endcase
    w_d_err  = w_d_mis || (d_req_addr < BASE_ADDR);
    w_if_err = (|if_req_addr[1:0]) || (if_req_addr < BASE_ADDR);
    w_addr   = w_d_gnt ? d_req_addr : if_req_addr;
    w_off    = w_addr[2:0];
    w_idx    = (w_addr - BASE_ADDR) >> 3;
    w_rd     = (w_if_gnt && !w_if_err) || (w_d_gnt && !d_req_wen && !w_d_err);
    w_wr     = w_d_gnt && d_req_wen && !w_d_err;
    unique case (d_req_size)
      2'd0:    w_lanes = 64'h0000_0000_0000_00FF;
      2'd1:    w_lanes = 64'h0000_0000_0000_FFFF;
      2'd2:    w_lanes = 64'h0000_0000_FFFF_FFFF;
      default: w_lanes = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign d_req_ready  = !rst;
  assign if_req_ready = !rst && !d_req_valid;
  assign ram_ren      = w_rd;
  assign ram_ridx     = w_rd ? w_idx : '0;
  assign ram_wen      = w_wr;
  assign ram_widx     = w_wr ? w_idx : '0;
  assign ram_wdata    = w_wr ? (d_req_wdata << {w_off, 3'b000}) : 64'd0;
  assign ram_wmask    = w_wr ? (w_lanes << {w_off, 3'b000}) : 64'd0;

  // Pending register: rewritten every cycle so a new grant can follow each response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wen    <= 1'b0;
      r_off    <= 3'd0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_d_gnt) begin
      r_state  <= PEND_D;
      r_wen    <= d_req_wen;
      r_off    <= d_req_addr[2:0];
      r_size   <= d_req_size;
      r_signed <= d_req_signed;
      r_err    <= w_d_err;
    end else if (w_if_gnt) begin
      r_state  <= PEND_IF;
      r_wen    <= 1'b0;
      r_off    <= if_req_addr[2:0];
      r_size   <= 2'd2;
      r_signed <= 1'b0;
      r_err    <= w_if_err;
    end else begin
      r_state  <= IDLE;
      r_err    <= 1'b0;
    end
  end

  // Load alignment and extension of the word returned by the RAM
  always_comb begin
    w_shift = ram_rdata >> {r_off, 3'b000};
    unique case (r_size)
      2'd0:    w_ext = {{56{r_signed & w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_ext = {{48{r_signed & w_shift[15]}}, w_shift[15:0]};
      2'd2:    w_ext = {{32{r_signed & w_shift[31]}}, w_shift[31:0]};
      default: w_ext = w_shift;
    endcase
  end

  // A response still pending when reset arrives is dropped
  assign if_rsp_valid = !rst && (r_state == PEND_IF);
  assign if_rsp_err   = if_rsp_valid && r_err;
  assign if_rsp_inst  = (if_rsp_valid && !r_err) ?
                        (r_off[2] ? ram_rdata[63:32] : ram_rdata[31:0]) : 32'd0;
  assign d_rsp_valid  = !rst && (r_state == PEND_D);
  assign d_rsp_err    = d_rsp_valid && r_err;
  assign d_rsp_rdata  = (d_rsp_valid && !r_err && !r_wen) ? w_ext : 64'd0;

endmodule

// File: doc/ram_bridge.md
# ram_bridge

Memory bridge between `zerocore`'s instruction-fetch and data-access ports and the single-read/single-write `RAMHelper` simulation memory.
- Arbitrates the two requesters onto one RAM read port and one write port.
- Converts byte addresses to 64-bit word indices.
- Builds write masks and aligns write data.
- Extracts, aligns and sign-extends load data; extracts the 32-bit instruction.
- Returns responses with fixed one-cycle latency. One new access can be granted every cycle.

## Interface
Parameters:
- `BASE_ADDR`, 64'h8000_0000, physical base of RAM; word index = (addr - BASE_ADDR) >> 3
- `ADDR_W`, 64, address and index width

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req_valid`  in  1  fetch request
- `if_req_ready`  out  1  fetch granted this cycle
- `if_req_addr`  in  64  fetch byte address
- `if_rsp_valid`  out  1  fetch response
- `if_rsp_inst`  out  32  fetched instruction
- `if_rsp_err`  out  1  misaligned or out-of-range fetch
- `d_req_valid`  in  1  data request
- `d_req_ready`  out  1  data granted this cycle
- `d_req_wen`  in  1  1 = store, 0 = load
- `d_req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- `d_req_signed`  in  1  sign-extend load result
- `d_req_addr`  in  64  data byte address
- `d_req_wdata`  in  64  store data, LSB-justified
- `d_rsp_valid`  out  1  data response (load data or store ack)
- `d_rsp_rdata`  out  64  load result; 0 for stores and errors
- `d_rsp_err`  out  1  misaligned or out-of-range access
- `ram_ren`, `ram_ridx`  out  1 / 64  RAM read enable / word index
- `ram_rdata`  in  64  RAM read data
- `ram_wen`, `ram_widx`  out  1 / 64  RAM write enable / word index
- `ram_wdata`, `ram_wmask`  out  64 / 64  RAM write data / bit mask

## Operation
**Arbitration (combinational)**
- `d_req_ready` = 1.
- `if_req_ready` = !`d_req_valid`. Data has fixed priority over fetch.

**Error check at grant**
- Misaligned: data requires addr[size-1:0] == 0; fetch requires addr[1:0] == 0.
- Out of range: addr < `BASE_ADDR`.
- An erroring request drives no `ram_ren`/`ram_wen`. It still gets a response one cycle later with err = 1 and data 0.

**Grant cycle, RAM drive (combinational)**
- Read grant (fetch, or data load): `ram_ren` = 1, `ram_ridx` = (addr - BASE_ADDR) >> 3.
- Store grant: `ram_wen` = 1, `ram_widx` from the same formula.
- `ram_wdata` = wdata << (8*addr[2:0]).
- `ram_wmask` = the size's byte lanes, each expanded to 8 bits and shifted by 8*addr[2:0]. Dword mask = all ones.
- All `ram_*` outputs are 0 when there is no grant.

**Pending register**
- Captured on each grant: port, write flag, offset addr[2:0], size, signed, err.
- States: IDLE, PEND_IF, PEND_D.
- Next state each cycle: PEND_D if data granted, else PEND_IF if fetch granted, else IDLE. It is updated every cycle regardless of current state (pipelined).

**Response (from pending register and `ram_rdata`)**
- PEND_IF: `if_rsp_valid` = 1. `if_rsp_inst` = offset[2] ? rdata[63:32] : rdata[31:0].
- PEND_D: `d_rsp_valid` = 1.
  - Load: rdata >> (8*offset), truncated to size, then sign- or zero-extended to 64 bits.
  - Store: rdata output = 0.
- Err pending: data output forced to 0, err = 1.
- IDLE: all rsp_valid = 0.

## Timing
- `ram_rdata` is valid the cycle after `ram_ren`. A write commits at the edge that ends the `ram_wen` cycle.
- Latency: grant in cycle N, response in cycle N+1, for both loads and stores.
- Throughput: one grant per cycle. A fetch request held against continuous data traffic waits indefinitely; the core guarantees data gaps.
- While `d_req_valid` = 1, a fetch stays un-granted and must hold its request.
- A store followed by a load to the same word in the next cycle returns the new data. The write commits before the read is sampled.
- Reset:
  - State returns to IDLE.
  - All rsp_valid, rsp data, err and `ram_*` outputs are 0 in the cycle after `rst` is sampled high.
  - A pending response is dropped.
  - No grants while `rst` = 1: both readies are 0.

## Test plan
- Fetch at 0x8000_0004, RAM word 0 = 0x00000013_00100093 → cycle N: `ram_ren` = 1, `ram_ridx` = 0; cycle N+1: `if_rsp_valid` = 1, inst = 0x00000013.
- Signed byte load at 0x8000_0013, word 2 = 0x00000000_80000000 → `ram_ridx` = 2; response 0xFFFF_FFFF_FFFF_FF80. Same access unsigned → 0x80.
- Half store 0xBEEF at 0x8000_000A → `ram_widx` = 1, `ram_wmask` = 0x0000_0000_FFFF_0000, `ram_wdata` = 0x0000_0000_BEEF_0000; `d_rsp_valid` next cycle with rdata 0.
- `if_req_valid` and `d_req_valid` both high in cycle N → `if_req_ready` = 0, data granted; `d_req_valid` drops in N+1 → fetch granted in N+1, `if_rsp_valid` in N+2.
- Word load at 0x8000_0002, and dword load at 0x7FFF_FFF8 → no `ram_ren`; next cycle `d_rsp_err` = 1, rdata 0.
- `rst` asserted in the cycle after a load grant → no `d_rsp_valid` afterwards; all outputs 0 until the first post-reset grant.
